blake2_block_feeder: RTL and testbench
======================================

# blake2_block_feeder

Message-side front end for the Blake2 compression cores. Accepts a message as a stream of little-endian W-bit words over a valid/ready handshake, packs 16 words into one block, zero-pads the final partial block, and maintains the Blake2 byte counter t and the final-block flag. It is the producer end of the block interface consumed by the Blake2 compression core, which needs the full block, t and the final flag for every compression.

## Interface
- W, 64, word width in bits (64 for Blake2b, 32 for Blake2s); block is 16*W bits, BB = 2*W bytes
- BW, $clog2(W/8)+1, width of in_bytes
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  feeder can accept a word this cycle
- in_data  in  W  message word, byte 0 at bits [7:0]
- in_last  in  1  word is the last of the message
- in_bytes  in  BW  valid bytes in a last word (0..W/8); ignored when in_last=0
- blk_valid  out  1  block, t, final valid
- blk_ready  in  1  core accepts block
- blk_data  out  16*W  block, word i at bits [i*W +: W]
- blk_t  out  2*W  byte counter for this block
- blk_final  out  1  last block of the message

## Operation
- Two states: FILL (collecting words, in_ready=1, blk_valid=0) and HOLD (block presented, in_ready=0, blk_valid=1).
- FILL, on in_valid & in_ready: store in_data into slot idx (4-bit), idx++. Non-last word: t += W/8. Last word: bytes at index >= in_bytes zeroed before storing; t += in_bytes.
- FILL -> HOLD when the accepted word is slot 15 or has in_last=1. blk_final = in_last of that word. Unfilled slots remain zero.
- A full block without in_last is emitted immediately as non-final; the producer guarantees more data follows.
- in_bytes=0 with in_last=1 is legal only as the first word of a message (empty message); it yields one all-zero block, t=0, final=1. Any other in_bytes=0 last word is a protocol violation, behaviour unspecified.
- HOLD, on blk_valid & blk_ready: clear blk_data and idx, go to FILL. If blk_final, clear t to 0 for the next message; otherwise t carries over.
- t arithmetic is modulo 2^(2W); no overflow detection.
- blk_data, blk_t, blk_final are registered and held stable for the whole of HOLD.

## Timing
- Reset (reset=1 at a rising edge): state FILL, idx=0, t=0, blk_valid=0, blk_data=0, blk_t=0, blk_final=0. in_ready=0 in any cycle where reset is high, 1 in the first cycle after.
- Reset mid-block or mid-HOLD discards the partial block and the pending block; no handshake completes in the reset cycle.
- blk_valid rises the cycle after the 16th or last word is accepted.
- in_ready rises the cycle after the blk handshake; no word accepted in the handshake cycle. Peak throughput: one block per 17 cycles.
- blk_valid never drops without blk_ready; in_valid may be held low arbitrarily in FILL without effect.

## Test plan
- Empty message: one word, in_last=1, in_bytes=0 -> one block, blk_data=0, blk_t=0, blk_final=1.
- "abc" (W=64): in_data=0x636261, in_last=1, in_bytes=3 with garbage in upper bytes -> word0=0x0000000000636261, other words 0, blk_t=3, blk_final=1, blk_valid one cycle after acceptance.
- 128-byte message (16 full words, last with in_bytes=8) -> single block, blk_t=128, blk_final=1; 129-byte message -> block 1 blk_t=128 final=0, block 2 word0=byte 128 only, blk_t=129 final=1.
- Backpressure: hold blk_ready=0 for 5 cycles during HOLD -> blk_valid, blk_data, blk_t, blk_final stable, in_ready=0 throughout, no input word consumed.
- Back-to-back messages: 200-byte then 3-byte message -> second message's block has blk_t=3 (t cleared after final).
- Reset after 7 words accepted, then "abc" -> single block word0=0x636261, blk_t=3, no remnant of the earlier words.

Source files
------------

// File: rtl/blake2_block_feeder.sv
// Message front end for the Blake2 compression cores: packs little-endian words
// into 16-word blocks, zero-pads the tail, and tracks byte counter t and final flag.

module blake2_block_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= '0;
        else if (load)
            q <= din;
    end
endmodule

module blake2_block_feeder #(
    parameter int W  = 64,
    parameter int BW = $clog2(W/8) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    input  logic [BW-1:0]   in_bytes,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic [16*W-1:0] blk_data,
    output logic [2*W-1:0]  blk_t,
    output logic            blk_final
);
    localparam int WB = W / 8;

    typedef enum logic {FILL, HOLD} state_t;

    state_t         state;
    logic [3:0]     idx;
    logic [2*W-1:0] t;
    logic [2*W-1:0] t_next;
    logic [W-1:0]   word_in;
    logic           accept;
    logic           blk_fire;

    assign in_ready = (state == FILL) && !reset;
    assign accept   = in_valid && in_ready;
    assign blk_fire = blk_valid && blk_ready;
    assign blk_t    = t;

    // Bytes at or above in_bytes of a last word are padding and must read as zero.
    always_comb begin
        word_in = in_data;
        for (int b = 0; b < WB; b++) begin
            if (in_last && (BW'(b) >= in_bytes))
                word_in[b*8 +: 8] = 8'h00;
        end
    end

    always_comb begin
        t_next = t + (in_last ? {{(2*W-BW){1'b0}}, in_bytes} : (2*W)'(WB));
    end

    for (genvar i = 0; i < 16; i++) begin : g_slot
        blake2_block_slot #(.W(W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .clr   (blk_fire),
            .load  (accept && (idx == 4'(i))),
            .din   (word_in),
            .q     (blk_data[i*W +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            t         <= '0;
            blk_valid <= 1'b0;
            blk_final <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        idx <= idx + 4'd1;
                        t   <= t_next;
                        if (idx == 4'd15 || in_last) begin
                            state     <= HOLD;
                            blk_valid <= 1'b1;
                            blk_final <= in_last;
                        end
                    end
                end
                HOLD: begin
                    if (blk_ready) begin
                        state     <= FILL;
                        blk_valid <= 1'b0;
                        blk_final <= 1'b0;
                        idx       <= '0;
                        // t only restarts at a message boundary.
                        if (blk_final)
                            t <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_blake2_block_feeder.sv
// Randomized bench for blake2_block_feeder; expected blocks are cut straight from
// the message byte array (128-byte chunks, zero tail, t = bytes consumed so far).

module tb_blake2_block_feeder;
    localparam int W  = 64;
    localparam int BW = $clog2(W/8) + 1;
    localparam int WB = W / 8;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic [BW-1:0]   in_bytes;
    logic            blk_valid;
    logic            blk_ready;
    logic [16*W-1:0] blk_data;
    logic [2*W-1:0]  blk_t;
    logic            blk_final;

    blake2_block_feeder #(.W(W), .BW(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_t     (blk_t),
        .blk_final (blk_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    byte unsigned msg[$];

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int pos);
        return (pos < msg.size()) ? msg[pos] : 8'h00;
    endfunction

    task automatic fill_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    // Streams msg through the DUT and checks every block; enters and leaves at a negedge in FILL.
    task automatic run_msg(input int hold, input bit rnd);
        int n, nw, nb, wi, bk, hold_left;
        bit exp_rise, prev_held, ev, done, in_fire, blk_fire;
        logic [W-1:0]    ew;
        logic [16*W-1:0] snap_d;
        logic [2*W-1:0]  snap_t;
        logic            snap_f;
        longint          et;
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        nb = (nw + 15) / 16;
        wi = 0; bk = 0; hold_left = 0;
        exp_rise = 0; prev_held = 0; done = 0;
        snap_d = '0; snap_t = '0; snap_f = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            ev = exp_rise | prev_held;
            chk("blk_valid", blk_valid, ev);
            chk("in_ready", in_ready, !ev);
            if (blk_valid && !prev_held && bk < nb) begin
                for (int k = 0; k < 16; k++) begin
                    for (int b = 0; b < WB; b++) ew[b*8 +: 8] = exp_byte(bk*128 + k*WB + b);
                    chk($sformatf("blk%0d_word%0d", bk, k), blk_data[k*W +: W], ew);
                end
                et = (128*(bk+1) < n) ? 128*(bk+1) : n;
                chk($sformatf("blk%0d_t", bk), blk_t, (2*W)'(et));
                chk($sformatf("blk%0d_final", bk), blk_final, bk == nb - 1);
                snap_d = blk_data; snap_t = blk_t; snap_f = blk_final;
                hold_left = hold;
            end else if (prev_held) begin
                for (int k = 0; k < 16; k++)
                    chk($sformatf("hold_word%0d", k), blk_data[k*W +: W], snap_d[k*W +: W]);
                chk("hold_t", blk_t, snap_t);
                chk("hold_final", blk_final, snap_f);
            end
            if (blk_valid && hold_left > 0) begin
                blk_ready = 1'b0;
                hold_left--;
            end else if (blk_valid) begin
                blk_ready = rnd ? 1'($urandom % 2) : 1'b1;
            end else begin
                blk_ready = rnd ? 1'($urandom % 2) : 1'b0;
            end
            in_valid = (wi < nw) && (rnd ? ($urandom % 4 != 0) : 1'b1);
            if (wi < nw) begin
                for (int b = 0; b < WB; b++)
                    in_data[b*8 +: 8] = (wi*WB + b < n) ? msg[wi*WB + b] : 8'($urandom);
                in_last  = (wi == nw - 1);
                in_bytes = in_last ? BW'(n - wi*WB) : BW'($urandom);
            end else begin
                in_data  = {$urandom, $urandom};
                in_last  = 1'($urandom);
                in_bytes = BW'($urandom);
            end
            in_fire  = in_valid && in_ready;
            blk_fire = blk_valid && blk_ready;
            exp_rise = in_fire && ((wi % 16 == 15) || (wi == nw - 1));
            if (in_fire) wi++;
            prev_held = blk_valid && !blk_fire;
            if (blk_fire) begin
                bk++;
                if (bk == nb) done = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        blk_ready = 1'b0;
        chk("msg_done", done, 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, blk_valid, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b1);
        chk({tag, "_t"}, blk_t, '0);
        chk({tag, "_final"}, blk_final, 1'b0);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_word%0d", tag, k), blk_data[k*W +: W], '0);
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; blk_ready = 1'b0;
        in_data = '0; in_last = 1'b0; in_bytes = '0;
        @(negedge clk); #1;
        chk("in_ready_in_reset", in_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; #1;
        chk_idle("reset");

        msg.delete();       run_msg(0, 0);  // empty message
        set_abc();          run_msg(0, 0);
        fill_msg(128);      run_msg(0, 0);
        fill_msg(129);      run_msg(0, 0);
        fill_msg(20);       run_msg(5, 0);  // backpressure
        fill_msg(200);      run_msg(0, 1);
        set_abc();          run_msg(0, 1);

        // Reset with 7 words already packed.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_last = 1'b0; in_data = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
        end
        chk("seven_no_valid", blk_valid, 1'b0);
        reset = 1'b1; #1;
        chk("in_ready_mid_reset", in_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; #1;
        chk_idle("reset_fill");
        set_abc();          run_msg(0, 0);

        // Reset while a block is presented.
        in_valid = 1'b1; in_last = 1'b1; in_bytes = BW'(WB); in_data = {$urandom, $urandom};
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("hold_before_reset", blk_valid, 1'b1);
        reset = 1'b1; blk_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; blk_ready = 1'b0; #1;
        chk_idle("reset_hold");
        set_abc();          run_msg(0, 0);

        for (int r = 0; r < 8; r++) begin
            fill_msg($urandom_range(0, 400));
            run_msg($urandom_range(0, 3), 1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
